// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolution slice.
//   rv32i_word   : 32-bit datapath word
//   bht_cnt_t    : 2-bit saturating predictor counter
//   BHT_RESET    : value every table entry takes on reset (weakly not-taken)
//   br_state_t   : redirect FSM states
//   bht_next()   : saturating counter update helper
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_t;

  localparam bht_cnt_t BHT_RESET = WNT;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } br_state_t;

  // Saturating step: taken moves toward ST, not-taken toward SNT.
  function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t nxt;
    nxt = cnt;
    unique case (cnt)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = BHT_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_bht.sv
// Branch history table: 2^IDX_BITS two-bit saturating counters.
//   clk, rst   : clock, synchronous active-high reset (all entries -> BHT_RESET)
//   rd_idx     : asynchronous lookup index
//   rd_cnt     : counter at rd_idx (value before any same-edge update)
//   upd_en     : apply a training update this cycle
//   upd_idx    : entry to train
//   upd_taken  : resolved direction used to train the entry
module bht
  import rv32i_types::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output bht_cnt_t            rd_cnt,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int ENTRIES = 1 << IDX_BITS;

  bht_cnt_t tbl [ENTRIES];

  // Read comes straight off the array, so a same-cycle update is not visible
  // until after the clock edge.
  assign rd_cnt = tbl[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= BHT_RESET;
      end
    end else if (upd_en) begin
      tbl[upd_idx] <= bht_next(tbl[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution in EX with a 2-bit BHT predictor and fetch redirect.
//   clk, rst                    : clock, synchronous active-high reset
//   if_pc / if_pred_taken       : fetch lookup and combinational prediction
//   ex_valid, ex_is_br/jal/jalr : EX occupancy and instruction class
//   ex_pc, ex_imm, ex_rs1       : EX operands for target calculation
//   br_en                       : branch comparator outcome
//   ex_pred_taken               : prediction that travelled with the EX instr
//   stall                       : pipeline freeze, blocks EX acceptance
//   redirect / redirect_pc      : registered fetch redirect and its target
//   br_count / mispred_count    : resolved-branch and misprediction counters
module branch_resolve
  import rv32i_types::*;
#(
  parameter int BHT_IDX_BITS = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  rv32i_word if_pc,
  output logic      if_pred_taken,
  input  logic      ex_valid,
  input  logic      ex_is_br,
  input  logic      ex_is_jal,
  input  logic      ex_is_jalr,
  input  rv32i_word ex_pc,
  input  rv32i_word ex_imm,
  input  rv32i_word ex_rs1,
  input  logic      br_en,
  input  logic      ex_pred_taken,
  input  logic      stall,
  output logic      redirect,
  output rv32i_word redirect_pc,
  output rv32i_word br_count,
  output rv32i_word mispred_count
);

  logic      accept_p0;
  logic      actual_taken_p0;
  logic      mispred_p0;
  rv32i_word target_p0;
  rv32i_word fallthrough_p0;
  rv32i_word next_pc_p0;
  bht_cnt_t  pred_cnt;
  br_state_t state;

  logic      unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:BHT_IDX_BITS+2], if_pc[1:0],
                            ex_pc[31:BHT_IDX_BITS+2], ex_pc[1:0]};

  bht #(
    .IDX_BITS (BHT_IDX_BITS)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (if_pc[BHT_IDX_BITS+1:2]),
    .rd_cnt    (pred_cnt),
    .upd_en    (accept_p0 && ex_is_br),
    .upd_idx   (ex_pc[BHT_IDX_BITS+1:2]),
    .upd_taken (br_en)
  );

  assign if_pred_taken = pred_cnt[1];

  // ---- EX resolve (combinational) ----
  always_comb begin
    // While a redirect is outstanding the EX slot holds a wrong-path instr.
    accept_p0       = ex_valid && !stall && !redirect;
    actual_taken_p0 = 1'b0;
    mispred_p0      = 1'b0;
    fallthrough_p0  = ex_pc + 32'd4;
    if (ex_is_jalr) begin
      target_p0 = (ex_rs1 + ex_imm) & ~32'h1;
    end else begin
      target_p0 = ex_pc + ex_imm;
    end
    if (ex_is_br) begin
      actual_taken_p0 = br_en;
      mispred_p0      = (br_en != ex_pred_taken);
    end else if (ex_is_jal || ex_is_jalr) begin
      // Jumps are never predicted, so they always redirect.
      actual_taken_p0 = 1'b1;
      mispred_p0      = 1'b1;
    end
    next_pc_p0 = actual_taken_p0 ? target_p0 : fallthrough_p0;
  end

  // ---- redirect FSM (registered outputs) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_p0 && mispred_p0) begin
            state       <= REDIR;
            redirect    <= 1'b1;
            redirect_pc <= next_pc_p0;
          end
        end
        REDIR: begin
          // Hold the request until fetch can actually see it unstalled.
          if (!stall) begin
            state    <= IDLE;
            redirect <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          redirect <= 1'b0;
        end
      endcase
    end
  end

  // ---- statistics counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (accept_p0 && ex_is_br) begin
        br_count <= br_count + 32'd1;
      end
      if (accept_p0 && mispred_p0) begin
        mispred_count <= mispred_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_is_br, ex_is_jal, ex_is_jalr;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic        br_en, ex_pred_taken, stall;
  logic        redirect;
  logic [31:0] redirect_pc, br_count, mispred_count;

  always #5 clk = ~clk;

  branch_resolve #(.BHT_IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .br_en(br_en), .ex_pred_taken(ex_pred_taken), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: counter values as plain integers 0..3 per table slot.
  int          m_tbl [16];
  bit          m_redir;
  logic [31:0] m_rpc, m_br, m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // cls: 0 = non-control, 1 = branch, 2 = jal, 3 = jalr
  task automatic cyc(input logic r, input logic v, input int cls,
                     input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                     input logic be, input logic pr, input logic st, input logic [31:0] ipc);
    bit          acc, taken, mis;
    logic [31:0] tgt;
    rst = r; ex_valid = v; ex_is_br = (cls == 1); ex_is_jal = (cls == 2);
    ex_is_jalr = (cls == 3); ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
    br_en = be; ex_pred_taken = pr; stall = st; if_pc = ipc;
    #1;
    chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, m_tbl[idx_of(ipc)] >= 2});
    // model update for this edge
    if (r) begin
      foreach (m_tbl[i]) m_tbl[i] = 1;
      m_redir = 0; m_rpc = 0; m_br = 0; m_mis = 0;
    end else begin
      acc   = v && !st && !m_redir;
      taken = (cls == 1) ? be : (cls >= 2);
      mis   = (cls == 1) ? (be != pr) : (cls >= 2);
      tgt   = (cls == 3) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
      if (m_redir) begin
        if (!st) m_redir = 0;
      end else if (acc && mis) begin
        m_redir = 1;
        m_rpc   = taken ? tgt : pc + 32'd4;
      end
      if (acc && cls == 1) begin
        m_tbl[idx_of(pc)] = be ? ((m_tbl[idx_of(pc)] == 3) ? 3 : m_tbl[idx_of(pc)] + 1)
                               : ((m_tbl[idx_of(pc)] == 0) ? 0 : m_tbl[idx_of(pc)] - 1);
        m_br = m_br + 1;
      end
      if (acc && mis) m_mis = m_mis + 1;
    end
    @(posedge clk);
    #1;
    chk("redirect", {31'd0, redirect}, {31'd0, m_redir});
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("br_count", br_count, m_br);
    chk("mispred_count", mispred_count, m_mis);
  endtask

  task automatic idle(input logic [31:0] ipc);
    cyc(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, ipc);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h100);
    cyc(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h100);
  endtask

  task automatic pred_at(input string name, input logic [31:0] ipc, input logic exp);
    if_pc = ipc;
    #1;
    chk(name, {31'd0, if_pred_taken}, {31'd0, exp});
  endtask

  initial begin
    foreach (m_tbl[i]) m_tbl[i] = 1;
    m_redir = 0; m_rpc = 0; m_br = 0; m_mis = 0;

    // Reset state
    do_reset();
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_br_count", br_count, 32'd0);
    chk("rst_mis_count", mispred_count, 32'd0);
    pred_at("rst_pred_0x100", 32'h100, 1'b0);

    // Taken branch mispredicted as not-taken
    cyc(0, 1, 1, 32'h100, 32'h20, 32'h0, 1, 0, 0, 32'h100);
    chk("br_redirect", {31'd0, redirect}, 32'd1);
    chk("br_redirect_pc", redirect_pc, 32'h120);
    chk("br_mis", mispred_count, 32'd1);
    pred_at("br_pred_after", 32'h100, 1'b1);
    idle(32'h100);

    // jalr, same table index as 0x100
    cyc(0, 1, 3, 32'h300, 32'h4, 32'h203, 0, 0, 0, 32'h100);
    chk("jalr_redirect_pc", redirect_pc, 32'h206);
    chk("jalr_br_count", br_count, 32'd1);
    chk("jalr_mis", mispred_count, 32'd2);
    pred_at("jalr_table_kept", 32'h100, 1'b1);
    idle(32'h100);

    // Three taken then one not-taken at 0x100: 01->10->11->11->10
    do_reset();
    cyc(0, 1, 1, 32'h100, 32'h20, 32'h0, 1, 1, 0, 32'h100);
    cyc(0, 1, 1, 32'h100, 32'h20, 32'h0, 1, 1, 0, 32'h100);
    cyc(0, 1, 1, 32'h100, 32'h20, 32'h0, 1, 1, 0, 32'h100);
    cyc(0, 1, 1, 32'h100, 32'h20, 32'h0, 0, 1, 0, 32'h100);
    chk("seq_br_count", br_count, 32'd4);
    chk("seq_redirect_pc", redirect_pc, 32'h104);
    pred_at("seq_pred_wt", 32'h100, 1'b1);
    idle(32'h100);
    // one more not-taken drops 10 -> 01, so prediction flips
    cyc(0, 1, 1, 32'h100, 32'h20, 32'h0, 0, 0, 0, 32'h100);
    pred_at("seq_pred_wnt", 32'h100, 1'b0);

    // Mispredict followed by three stalled cycles
    do_reset();
    cyc(0, 1, 1, 32'h100, 32'h20, 32'h0, 1, 0, 0, 32'h100);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 32'h100, 32'h20, 32'h0, 1, 0, 1, 32'h100);
      chk("stall_redirect_held", {31'd0, redirect}, 32'd1);
    end
    cyc(0, 1, 1, 32'h100, 32'h20, 32'h0, 1, 0, 0, 32'h100);
    chk("stall_redirect_clear", {31'd0, redirect}, 32'd0);
    chk("stall_br_count", br_count, 32'd1);
    chk("stall_mis_count", mispred_count, 32'd1);

    // Mispredict accepted while rst is high
    cyc(0, 1, 1, 32'h100, 32'h20, 32'h0, 1, 1, 0, 32'h100);
    cyc(1, 1, 2, 32'h100, 32'h40, 32'h0, 0, 0, 0, 32'h100);
    chk("rst_acc_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_acc_br", br_count, 32'd0);
    chk("rst_acc_mis", mispred_count, 32'd0);
    pred_at("rst_acc_pred", 32'h100, 1'b0);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc, ripc;
      rpc  = 32'h1000 + {$urandom_range(0, 31), 2'b00};
      ripc = 32'h1000 + {$urandom_range(0, 31), 2'b00};
      if ($urandom_range(0, 15) == 0) rpc = $urandom;
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 3)), rpc, $urandom, $urandom,
          1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), ripc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter BHT_IDX_BITS, default 4, meaning log2 of the branch-history-table entry count (table indexed by pc[BHT_IDX_BITS+1:2]).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port if_pc  input  32  fetch-stage PC used for prediction lookup.
REQ-005 SHALL have port if_pred_taken  output  1  prediction for if_pc, taken when the counter MSB is 1 (combinational read).
REQ-006 SHALL have port ex_valid  input  1  an instruction occupies EX this cycle.
REQ-007 SHALL have ports ex_is_br, ex_is_jal, ex_is_jalr  input  1 each  EX instruction class; at most one is high.
REQ-008 SHALL have ports ex_pc, ex_imm, ex_rs1  input  32 each  EX PC, sign-extended immediate, rs1 value (rv32i_word).
REQ-009 SHALL have port br_en  input  1  branch comparator result for the EX instruction.
REQ-010 SHALL have port ex_pred_taken  input  1  prediction carried down the pipe with the EX instruction.
REQ-011 SHALL have port stall  input  1  pipeline freeze; EX is not accepted while high.
REQ-012 SHALL have ports redirect  output  1  and redirect_pc  output  32  registered fetch redirect request and its target.
REQ-013 SHALL have ports br_count, mispred_count  output  32 each  resolved-branch and misprediction counters.

Function
REQ-014 EX accept SHALL occur when ex_valid && !stall && !redirect; all other cycles perform no table or counter update.
REQ-015 actual_taken SHALL be br_en for ex_is_br, 1 for ex_is_jal/ex_is_jalr, 0 otherwise.
REQ-016 target SHALL be (ex_rs1+ex_imm) & ~32'h1 for jalr and ex_pc+ex_imm otherwise, modulo 2^32; fallthrough SHALL be ex_pc+4 modulo 2^32.
REQ-017 mispredict SHALL be (actual_taken != ex_pred_taken) for branches; jal/jalr SHALL always mispredict; non-control instructions SHALL never mispredict.
REQ-018 FSM states SHALL be IDLE and REDIR; on accept with mispredict, IDLE->REDIR next cycle and redirect_pc latches actual_taken ? target : fallthrough.
REQ-019 In REDIR, redirect SHALL be 1; state SHALL hold while stall=1 and return to IDLE the first cycle stall=0 (redirect high for exactly one unstalled cycle).
REQ-020 The EX instruction present in any cycle with redirect=1 is wrong-path and SHALL be dropped (no accept, no update).
REQ-021 On accept of a branch, the 2-bit counter at ex_pc's index SHALL saturating-increment if taken, saturating-decrement otherwise (11 stays 11, 00 stays 00); jal/jalr SHALL NOT update the table.
REQ-022 A lookup and an update to the same index in one cycle SHALL return the pre-update value.
REQ-023 br_count SHALL increment on each accepted branch; mispred_count on each accepted mispredicting branch or jump; both wrap 32'hFFFF_FFFF->0.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, redirect=0, redirect_pc=0, br_count=0, mispred_count=0, every table entry=2'b01.
REQ-025 rst SHALL override any in-flight redirect or simultaneous accept; nothing from that cycle is retained.
REQ-026 After reset, if_pred_taken SHALL be 0 for every if_pc.

Structure
REQ-027 bht_cnt_t (2-bit enum SNT=00, WNT=01, WT=10, ST=11) and BHT reset value SHALL be added to package rv32i_types; rv32i_word SHALL be used for all 32-bit data.
REQ-028 The counter table SHALL be a sub-module named bht (one async read port, one sync update port, synchronous reset).

Verification
REQ-029 Reset, then if_pc=0x100 -> if_pred_taken=0; counters 0; redirect=0.
REQ-030 Branch ex_pc=0x100, imm=0x20, br_en=1, pred=0 -> next cycle redirect=1, redirect_pc=0x120, mispred_count=1, entry 01->10, if_pc=0x100 predicts taken.
REQ-031 jalr ex_rs1=0x203, imm=0x4 -> redirect_pc=0x206; table unchanged; br_count unchanged, mispred_count+1.
REQ-032 Three taken branches at 0x100 then one not-taken -> counter 01->10->11->11->10; br_count=4.
REQ-033 Mispredict with stall=1 for 3 cycles after -> redirect held 3 stalled cycles plus one unstalled cycle; EX valid during redirect dropped (counters unchanged).
REQ-034 Mispredict accepted in same cycle rst=1 -> next cycle redirect=0, all counters 0, entries 01.
